mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's memory interface.
- Serves word reads, word writes, and sign/zero-extended byte reads (LB/LBU) from an internal word array.
- Uses a req/ready handshake with a fixed, parameterised access latency so the controller can stall on slow memory.
- Sits between the datapath memory address/data bus and the controller.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the array (power of two, 4..1024).
- LATENCY, 2, cycles from request acceptance to the ready pulse (legal range 1..15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  request strobe; sampled only in IDLE.
- we  input  1  1 = write, 0 = read.
- addr  input  32  byte address.
- wdata  input  32  write data.
- lb  input  2  access size: 00 word; 01 byte signed (LB); 10 byte unsigned (LBU); 11 treated as word.
- rdata  output  32  read data; valid while ready=1, held until the next response.
- ready  output  1  one-cycle completion pulse.
- err  output  1  error flag; valid with ready, held until the next response.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, latency counter=0, ready=0, err=0, rdata=0, busy=0. Array contents are not reset.
- Reset while in WAIT: aborts the access; a pending write is discarded and the array is unchanged.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req=1 at edge k accepts the request and latches addr, we, wdata, lb.
  - Counter loads LATENCY-1; next state is WAIT.
  - If LATENCY=1, next state is RESP directly.
- WAIT: counter decrements each cycle; at counter==0 the next state is RESP.
- Timing: ready=1 during exactly cycle k+LATENCY (the RESP cycle), then the FSM returns to IDLE.
- req while busy or during RESP is ignored; it is not queued.
- A new request can be accepted in the cycle after RESP. Back-to-back period is LATENCY+1 cycles.
- Commit point: the array write and the rdata/err register update occur on the edge entering RESP.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Bytes are little-endian: byte offset 0 is bits 7:0, offset 3 is bits 31:24.
- Read, lb=00/11: rdata = mem[index].
- Read, lb=01: rdata = selected byte sign-extended to 32 bits.
- Read, lb=10: rdata = selected byte zero-extended to 32 bits.
- Write (only with lb=00/11): mem[index] <= wdata; rdata returns wdata.
- Error conditions: err=1, rdata=0, no array write. Any of:
  - word access with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS (no wrap-around);
  - we=1 with lb=01/10 (byte stores unsupported).
- All error cases still complete with the normal ready timing.
- A read of a word written by the immediately preceding write returns the new value, since the write is committed before the next acceptance.

Test Plan:
- Write then read, LATENCY=2: write addr=0x10, wdata=0xDEADBEEF accepted at edge 0 -> ready=1 in cycle 2 only, err=0. Word read of addr=0x10 accepted at edge 3 -> ready in cycle 5, rdata=0xDEADBEEF.
- Byte extension: mem[0]=0x12345680. LB addr=0x0 -> rdata=0xFFFFFF80. LBU addr=0x0 -> 0x00000080. LB addr=0x3 -> 0x00000012. LBU addr=0x2 -> 0x00000034.
- Errors: word read addr=0x6 -> ready, err=1, rdata=0. Read addr=0x100 with DEPTH_WORDS=64 -> err=1. Write with lb=01 -> err=1, and a subsequent word read shows the word unchanged.
- Handshake: req held high continuously with LATENCY=3 -> acceptances at edges 0, 4, 8. ready pulses in cycles 3, 7, 11. busy low only in cycles 4, 8 (IDLE).
- Reset mid-operation: write of 0xAAAAAAAA to addr=0x8 (previously 0x11111111), LATENCY=4, reset=0 asserted in cycle 2 -> ready, err, rdata, busy go to 0 immediately. After reset release, a read of 0x8 returns 0x11111111.
- LATENCY=1: read accepted at edge 0 -> ready in cycle 1. busy=1 only in cycle 1.

Source files
------------

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//
// Memory-side responder for the multicycle MIPS core. Serves word reads,
// word writes and sign/zero-extended byte reads (LB/LBU) from an internal
// word array. The access completes a fixed LATENCY cycles after it is
// accepted, which lets the controller stall on slow memory.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   req    - request strobe, only sampled while idle
//   we     - 1 = write, 0 = read
//   addr   - byte address
//   wdata  - write data
//   lb     - access size: 00 word, 01 byte signed, 10 byte unsigned, 11 word
//   rdata  - response data, valid with ready and held until the next response
//   ready  - one-cycle completion pulse
//   err    - error flag, valid with ready and held until the next response
//   busy   - high while an access is in flight (not idle)
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  lb,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic        commit;

    // Latched request fields (data only, no reset needed)
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  lb_q;

    // Request currently being served
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [1:0]  cur_lb;

    logic          is_word;
    logic [AW-1:0] idx;
    logic          out_of_range;
    logic          misaligned;
    logic          byte_store;
    logic          acc_err;
    logic [31:0]   word;
    logic [31:0]   resp_data;

    logic [31:0] mem [DEPTH_WORDS];

    // Selects one little-endian byte of a word and widens it to 32 bits,
    // sign-extending for LB and zero-extending for LBU.
    function automatic logic [31:0] byte_extend(input logic [31:0] w,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic        [7:0]  b;
        logic signed [7:0]  sb;
        logic signed [31:0] sx;
        b  = w[8*off +: 8];
        sb = b;
        sx = sb;
        return sgn ? 32'(sx) : {24'd0, b};
    endfunction

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // ---------------- FSM next state ----------------
    // commit marks the edge that enters RESP: the array write and the
    // response registers both update on that edge.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- request capture ----------------
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            lb_q    <= lb;
        end
    end

    // With LATENCY=1 the commit happens on the accepting edge itself, so the
    // live inputs are used while idle and the latched copy afterwards.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = we;
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_lb    = lb;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_lb    = lb_q;
        end
    end

    // ---------------- access decode ----------------
    always_comb begin
        is_word      = (cur_lb == 2'b00) || (cur_lb == 2'b11);
        idx          = cur_addr[AW+1:2];
        out_of_range = |cur_addr[31:AW+2];
        misaligned   = is_word && (cur_addr[1:0] != 2'b00);
        byte_store   = cur_we && !is_word;
        acc_err      = out_of_range || misaligned || byte_store;
        word         = mem[idx];

        if (acc_err) begin
            resp_data = 32'd0;
        end else if (cur_we) begin
            resp_data = cur_wdata;
        end else if (is_word) begin
            resp_data = word;
        end else begin
            resp_data = byte_extend(word, cur_addr[1:0], cur_lb == 2'b01);
        end
    end

    // ---------------- array write ----------------
    always_ff @(posedge clk) begin
        if (commit && cur_we && !acc_err) begin
            mem[idx] <= cur_wdata;
        end
    end

    // ---------------- response registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'd0;
            err   <= 1'b0;
        end else if (commit) begin
            rdata <= resp_data;
            err   <= acc_err;
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_responder
//
// Drives four mem_responder instances (LATENCY 1..4, DEPTH_WORDS 64) that
// share address/data inputs but have separate request strobes, and compares
// them against a word-array reference model of the access rules.
// ---------------------------------------------------------------------------
module tb_mem_responder;

    localparam int DEPTH = 64;
    localparam int NDUT  = 4;
    localparam int LAT [NDUT] = '{1, 2, 3, 4};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NDUT-1:0] req_v;
    logic            we;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [1:0]      lb;
    logic [31:0]     rdata_v [NDUT];
    logic [NDUT-1:0] ready_v;
    logic [NDUT-1:0] err_v;
    logic [NDUT-1:0] busy_v;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (LAT[g])
        ) u_dut (
            .clk   (clk),
            .reset (rst_n),
            .req   (req_v[g]),
            .we    (we),
            .addr  (addr),
            .wdata (wdata),
            .lb    (lb),
            .rdata (rdata_v[g]),
            .ready (ready_v[g]),
            .err   (err_v[g]),
            .busy  (busy_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: applies one access to model_mem and returns the
    // expected response.
    function automatic void model_access(input logic w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [1:0] size,
                                         output logic e, output logic [31:0] r);
        int unsigned widx;
        int unsigned off;
        int unsigned b;
        bit          word_acc;
        widx     = a / 4;
        off      = a % 4;
        word_acc = (size == 2'd0) || (size == 2'd3);
        e = (widx >= DEPTH) || (word_acc && off != 0) || (w && !word_acc);
        r = 32'd0;
        if (!e) begin
            if (w) begin
                model_mem[widx] = d;
                r = d;
            end else if (word_acc) begin
                r = model_mem[widx];
            end else begin
                b = (model_mem[widx] >> (8 * off)) & 32'hFF;
                if (size == 2'd1 && b >= 128) r = b + 32'hFFFFFF00;
                else                          r = b;
            end
        end
    endfunction

    // Issues one access to the DUTs selected by mask and checks every cycle
    // until all of them are idle again. Entered and left on a falling edge
    // with all DUTs idle.
    task automatic run_access(input logic [NDUT-1:0] mask, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] size, input bit use_exp,
                              input logic [31:0] exp_rd, input logic exp_err);
        logic        e;
        logic [31:0] r;
        model_access(w, a, d, size, e, r);
        if (use_exp) begin
            r = exp_rd;
            e = exp_err;
        end
        we    = w;
        addr  = a;
        wdata = d;
        lb    = size;
        req_v = mask;
        @(negedge clk);
        req_v = '0;
        for (int cyc = 1; cyc <= 5; cyc++) begin
            for (int i = 0; i < NDUT; i++) begin
                if (mask[i]) begin
                    check_eq($sformatf("d%0d c%0d ready a=%h", i, cyc, a),
                             32'(ready_v[i]), 32'(cyc == LAT[i]));
                    check_eq($sformatf("d%0d c%0d busy a=%h", i, cyc, a),
                             32'(busy_v[i]), 32'(cyc <= LAT[i]));
                    if (cyc >= LAT[i]) begin
                        check_eq($sformatf("d%0d c%0d rdata a=%h lb=%0d we=%0b", i, cyc, a, size, w),
                                 rdata_v[i], r);
                        check_eq($sformatf("d%0d c%0d err a=%h lb=%0d we=%0b", i, cyc, a, size, w),
                                 32'(err_v[i]), 32'(e));
                    end
                end
            end
            if (cyc < 5) @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        logic [1:0]  rs;
        logic        rw;
        int          mod;

        rst_n = 1'b0;
        req_v = '0;
        we    = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        lb    = 2'd0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NDUT; i++) begin
            check_eq($sformatf("rst d%0d rdata", i), rdata_v[i], 32'd0);
            check_eq($sformatf("rst d%0d ready", i), 32'(ready_v[i]), 32'd0);
            check_eq($sformatf("rst d%0d err", i), 32'(err_v[i]), 32'd0);
            check_eq($sformatf("rst d%0d busy", i), 32'(busy_v[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value
        for (int w = 0; w < DEPTH; w++) begin
            run_access('1, 1'b1, 32'(w * 4), $urandom, 2'd0, 1'b0, 32'd0, 1'b0);
        end

        // Write then read back
        run_access('1, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b1, 32'hDEADBEEF, 1'b0);
        run_access('1, 1'b0, 32'h10, 32'h0,       2'd0, 1'b1, 32'hDEADBEEF, 1'b0);

        // Byte extension
        run_access('1, 1'b1, 32'h0, 32'h12345680, 2'd0, 1'b1, 32'h12345680, 1'b0);
        run_access('1, 1'b0, 32'h0, 32'h0, 2'd1, 1'b1, 32'hFFFFFF80, 1'b0);
        run_access('1, 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 32'h00000080, 1'b0);
        run_access('1, 1'b0, 32'h3, 32'h0, 2'd1, 1'b1, 32'h00000012, 1'b0);
        run_access('1, 1'b0, 32'h2, 32'h0, 2'd2, 1'b1, 32'h00000034, 1'b0);
        run_access('1, 1'b0, 32'h0, 32'h0, 2'd3, 1'b1, 32'h12345680, 1'b0);

        // Error cases
        run_access('1, 1'b0, 32'h6,   32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
        run_access('1, 1'b0, 32'h100, 32'h0, 2'd0, 1'b1, 32'h0, 1'b1);
        run_access('1, 1'b0, 32'h101, 32'h0, 2'd2, 1'b1, 32'h0, 1'b1);
        run_access('1, 1'b0, 32'hFC,  32'h0, 2'd0, 1'b0, 32'h0, 1'b0);
        run_access('1, 1'b1, 32'h20,  32'hCAFEF00D, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0);
        run_access('1, 1'b1, 32'h20,  32'h55555555, 2'd1, 1'b1, 32'h0, 1'b1);
        run_access('1, 1'b1, 32'h21,  32'h55555555, 2'd2, 1'b1, 32'h0, 1'b1);
        run_access('1, 1'b0, 32'h20,  32'h0, 2'd0, 1'b1, 32'hCAFEF00D, 1'b0);

        // req held high continuously: one access every LATENCY+1 cycles
        we    = 1'b0;
        addr  = 32'h10;
        lb    = 2'd0;
        req_v = '1;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NDUT; i++) begin
                mod = c % (LAT[i] + 1);
                check_eq($sformatf("hs d%0d c%0d ready", i, c), 32'(ready_v[i]),
                         32'(c > 0 && mod == LAT[i]));
                check_eq($sformatf("hs d%0d c%0d busy", i, c), 32'(busy_v[i]),
                         32'(mod != 0));
                if (c > 0 && mod == LAT[i])
                    check_eq($sformatf("hs d%0d c%0d rdata", i, c), rdata_v[i], 32'hDEADBEEF);
            end
            @(negedge clk);
        end
        req_v = '0;
        repeat (6) @(negedge clk);

        // Reset in the middle of a LATENCY=4 write aborts it
        run_access('1, 1'b1, 32'h8, 32'h11111111, 2'd0, 1'b1, 32'h11111111, 1'b0);
        we    = 1'b1;
        addr  = 32'h8;
        wdata = 32'hAAAAAAAA;
        lb    = 2'd0;
        req_v = 4'b1000;
        @(negedge clk);
        req_v = '0;
        check_eq("abort busy before reset", 32'(busy_v[3]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("abort ready", 32'(ready_v[3]), 32'd0);
        check_eq("abort err",   32'(err_v[3]),   32'd0);
        check_eq("abort rdata", rdata_v[3],      32'd0);
        check_eq("abort busy",  32'(busy_v[3]),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_access('1, 1'b0, 32'h8, 32'h0, 2'd0, 1'b1, 32'h11111111, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            rs = 2'($urandom_range(0, 3));
            rw = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) ra = $urandom;
            else                           ra = 32'($urandom_range(0, 4 * DEPTH + 15));
            if ((rs == 2'd0 || rs == 2'd3) && $urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if (rw && $urandom_range(0, 3) != 0 && rs != 2'd3) rs = 2'd0;
            run_access('1, rw, ra, $urandom, rs, 1'b0, 32'd0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
